varint_stream_sched: RTL

//  Shares one varint serializer between NUM_REQ field producers and emits

---
 rtl/varint_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 22 ++
 rtl/varint_stream_sched.sv | 69 ++++++
 3 files changed

// File: rtl/varint_pkg.sv
// varint_pkg: shared types and helpers for the varint stream scheduler
package varint_pkg;
  localparam int MAX_VARINT_BYTES = 10;
  typedef enum logic {IDLE, EMIT} sched_state_e;
  function automatic int varint_len(input logic [63:0] value);
    int n;
    n = 1;
    while (value >= 64'd128) begin
      value = value >> 7;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, wrapping upward
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/varint_stream_sched.sv
// varint_stream_sched: round-robin shared protobuf varint serializer, one byte per handshake
module varint_stream_sched
  import varint_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 64,
  localparam int SRC_W = $clog2(NUM_REQ),
  localparam int MAX_BYTES = ((DATA_WIDTH - 1) / 7) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_first,
  output logic                          out_last,
  output logic [SRC_W-1:0]              out_src,
  output logic                          busy
);
  localparam int CNT_W = $clog2(MAX_BYTES);
  sched_state_e state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [SRC_W-1:0] ptr, win_idx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_arr;
  logic cont;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(win_idx)
  );
  assign req_arr = req_data;
  assign cont = |shreg[DATA_WIDTH-1:7];
  assign busy = state == EMIT;
  assign out_valid = busy;
  assign req_ready = busy ? '0 : grant;
  assign out_byte = {cont, shreg[6:0]};
  assign out_first = busy && cnt == '0;
  assign out_last = busy && !cont;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      ptr <= '0;
      out_src <= '0;
    end else if (state == IDLE) begin
      if (|req_valid) begin
        shreg <= req_arr[win_idx];
        out_src <= win_idx;
        cnt <= '0;
        ptr <= (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : SRC_W'(win_idx + 1'b1);
        state <= EMIT;
      end
    end else if (out_ready) begin
      if (cont) begin
        shreg <= shreg >> 7;
        cnt <= cnt + 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
